// File: rtl/reg_serializer.sv
// reg_serializer: parallel-in, serial-out reader for the register datapath.
// Accepts one WIDTH-bit word via a valid/ready load handshake and shifts it
// out MSB-first, one bit per accepted cycle, via a valid/ready serial handshake.
//
// Optional feature macro: SER_PARITY_EN
//   When defined, an even-parity bit is appended after the last data bit and
//   sout_last flags that parity bit instead of the final data bit.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   D           in   parallel word, sampled only on a load handshake
//   load_valid  in   producer has a word on D
//   load_ready  out  block can accept a word (idle)
//   sout        out  current serial bit, 0 when sout_valid is low
//   sout_valid  out  sout holds a valid bit
//   sout_last   out  current bit is the final bit of the word
//   sout_ready  in   consumer accepts the current bit this cycle
//   busy        out  inverse of load_ready
module reg_serializer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    input  logic             sout_ready,
    output logic             busy
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [CntW-1:0]  cnt;
`ifdef SER_PARITY_EN
    logic             par;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            shreg <= '0;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (load_valid) begin
                        shreg <= D;
                        cnt   <= '0;
`ifdef SER_PARITY_EN
                        par   <= ^D;
`endif
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (sout_ready) begin
                        shreg <= shreg << 1;
                        if (cnt == LastCnt) begin
`ifdef SER_PARITY_EN
                            state <= StParity;
`else
                            state <= StIdle;
`endif
                        end else begin
                            // Hold at the last index rather than wrapping.
                            cnt <= cnt + CntW'(1);
                        end
                    end
                end
`ifdef SER_PARITY_EN
                StParity: begin
                    if (sout_ready) begin
                        state <= StIdle;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

    // All outputs decode purely from registered state; no input reaches an output.
    always_comb begin
        load_ready = (state == StIdle);
        busy       = (state != StIdle);
        sout_valid = (state != StIdle);
        sout       = 1'b0;
        sout_last  = 1'b0;
        if (state == StShift) begin
            sout = shreg[WIDTH-1];
`ifndef SER_PARITY_EN
            sout_last = (cnt == LastCnt);
`endif
        end
`ifdef SER_PARITY_EN
        if (state == StParity) begin
            sout      = par;
            sout_last = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_reg_serializer.sv
// Self-checking bench for reg_serializer (WIDTH = 32). Works with or without
// SER_PARITY_EN; the expected stream length and last-bit position follow it.
module tb_reg_serializer;

    localparam int unsigned WIDTH = 32;
`ifdef SER_PARITY_EN
    localparam int unsigned NB = WIDTH + 1;
`else
    localparam int unsigned NB = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] D;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             sout_ready;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    reg_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D          (D),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .sout_ready (sout_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int i);
        if (i < int'(WIDTH)) return w[WIDTH-1-i];
        return ^w;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_load_ready"}, 64'(load_ready), 64'd1);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_sout_valid"}, 64'(sout_valid), 64'd0);
        check({tag, "_sout"},       64'(sout),       64'd0);
        check({tag, "_sout_last"},  64'(sout_last),  64'd0);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] w);
        for (int k = 0; k < 20 && !load_ready; k++) tick();
        check("load_ready_before_load", 64'(load_ready), 64'd1);
        D          = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        D          = WIDTH'($urandom);
    endtask

    // Stream up to 'limit' bits. toggle: sout_ready = 0,1,0,1...; poke: drive
    // load_valid with junk on D while busy, which must be ignored.
    task automatic stream(input logic [WIDTH-1:0] w, input bit toggle, input bit poke,
                          input int limit);
        int idx = 0;
        int cyc = 0;
        logic rdy;
        while (idx < limit && cyc < 4 * int'(NB) + 10) begin
            rdy        = toggle ? cyc[0] : 1'b1;
            sout_ready = rdy;
            load_valid = poke;
            D          = WIDTH'($urandom);
            check("sout_valid", 64'(sout_valid), 64'd1);
            check("load_ready_busy", 64'(load_ready), 64'd0);
            check($sformatf("sout_bit%0d", idx), 64'(sout), 64'(exp_bit(w, idx)));
            check($sformatf("sout_last_bit%0d", idx), 64'(sout_last),
                  64'(idx == int'(NB) - 1));
            tick();
            if (rdy) idx++;
            cyc++;
        end
        load_valid = 1'b0;
        sout_ready = 1'b0;
        check("bits_taken", 64'(idx), 64'(limit));
        if (limit == int'(NB)) begin
            check("cycles", 64'(cyc), toggle ? 64'(2 * NB) : 64'(NB));
            check_idle("after_word");
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        D          = '0;
        load_valid = 1'b0;
        sout_ready = 1'b0;

        // Reset held with random inputs.
        for (int k = 0; k < 5; k++) begin
            load_valid = 1'($urandom);
            sout_ready = 1'($urandom);
            D          = WIDTH'($urandom);
            tick();
            check_idle("reset");
        end
        load_valid = 1'b0;
        sout_ready = 1'b0;
        rst_n      = 1'b1;
        tick();
        check_idle("post_reset");

        // All-zero word, consumer always ready.
        do_load(32'h0000_0000);
        stream(32'h0000_0000, 1'b0, 1'b0, NB);

        // Back-to-back loads with junk load_valid while busy.
        do_load(32'hFFFF_FFFC);
        stream(32'hFFFF_FFFC, 1'b0, 1'b1, NB);
        do_load(32'hFFFF_1FFC);
        stream(32'hFFFF_1FFC, 1'b0, 1'b1, NB);
        do_load(32'hFF8F_1FFC);
        stream(32'hFF8F_1FFC, 1'b0, 1'b1, NB);

        // Stalls on every other cycle.
        do_load(32'hFFFF_FFFC);
        stream(32'hFFFF_FFFC, 1'b1, 1'b0, NB);

        // Reset mid-word after 10 bits, then a clean word.
        do_load(32'hA5A5_A5A5);
        stream(32'hA5A5_A5A5, 1'b0, 1'b0, 10);
        check("midword_valid", 64'(sout_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        tick();
        check_idle("async_reset_held");
        rst_n = 1'b1;
        tick();
        check_idle("after_release");
        do_load(32'h0000_000F);
        stream(32'h0000_000F, 1'b0, 1'b0, NB);

        // Single one: parity bit is 1 when parity is enabled.
        do_load(32'h0000_0001);
        stream(32'h0000_0001, 1'b0, 1'b0, NB);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
